alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand/result width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operation request.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 SHALL have port alu_a, input, WIDTH, signed operand A.
REQ-007 SHALL have port alu_b, input, WIDTH, signed operand B.
REQ-008 SHALL have port alu_op, input, 5, opcode.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port alu_out, output, WIDTH, registered result.
REQ-012 SHALL have port flag_zero, output, 1; flag_carry, output, 1; flag_ovf, output, 1, registered status flags.

Function
REQ-013 SHALL use opcodes: 00 NOP (0), 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 NOR, 07 SLT (signed a<b gives 1, else 0), 08 SLL, 09 SRL, 0A SRA, 0B MUL (low WIDTH bits of a*b).
REQ-014 SHALL produce result 0 with all flags 0 for any undefined opcode (0C-1F).
REQ-015 SHALL use shift amount alu_b[log2(WIDTH)-1:0] and ignore the upper bits of alu_b.
REQ-016 SHALL implement an FSM with states IDLE, MUL and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; acceptance is an edge with in_valid=1 and in_ready=1.
REQ-018 SHALL capture alu_a, alu_b and alu_op at acceptance; later input changes have no effect on the operation in flight.
REQ-019 SHALL go IDLE->DONE for any non-MUL opcode, so out_valid rises 1 cycle after the acceptance edge.
REQ-020 SHALL go IDLE->MUL for MUL; MUL runs radix-2 shift-add iterations with a counter for exactly WIDTH cycles, then goes to DONE, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-021 SHALL assert out_valid only in DONE, and hold alu_out and the flags stable while out_valid=1 and out_ready=0.
REQ-022 SHALL go DONE->IDLE on an edge with out_ready=1; a new request cannot be accepted on that same edge.
REQ-023 SHALL ignore in_valid in MUL and DONE, with no queuing.
REQ-024 SHALL set flag_zero = (alu_out == 0) for every defined opcode.
REQ-025 SHALL set flag_carry = unsigned carry-out for ADD, unsigned borrow (a<b) for SUB, and 0 otherwise.
REQ-026 SHALL set flag_ovf = signed overflow for ADD and SUB, and 0 otherwise, including MUL.

Reset
REQ-027 SHALL, when rst=1 on an edge, set state to IDLE, and alu_out, all flags, out_valid and the counter to 0.
REQ-028 SHALL, while rst=1, drive in_ready=1 from the next cycle and accept no operation.
REQ-029 SHALL give rst priority over every other event, including mid-MUL and in DONE; any pending result is discarded.

Verification
REQ-030 SHALL cover, at WIDTH=32: ADD 0x7FFFFFFF+0x00000001 -> 1 cycle later alu_out=0x80000000, ovf=1, carry=0, zero=0.
REQ-031 SHALL cover: SUB 5-5 -> alu_out=0, zero=1, carry=0; then SUB 0-1 -> alu_out=0xFFFFFFFF, carry=1, ovf=0.
REQ-032 SHALL cover: a=0x80000000, b=36 -> SRA gives 0xF8000000, SRL gives 0x08000000, SLL gives 0x00000000 with zero=1.
REQ-033 SHALL cover: MUL 0xFFFFFFFF*3 -> in_ready=0 for 33 cycles, out_valid rises exactly 33 cycles after acceptance, alu_out=0xFFFFFFFD.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> alu_out and flags unchanged, in_ready=0; then out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-035 SHALL cover: rst pulsed on MUL iteration 10 -> next cycle out_valid=0, alu_out=0, in_ready=1; no result ever appears.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add multiply,
// valid/ready handshake on both sides with a registered result and flags.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [4:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH);

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_XOR = 5'h05;
  localparam logic [4:0] OP_NOR = 5'h06;
  localparam logic [4:0] OP_SLT = 5'h07;
  localparam logic [4:0] OP_SLL = 5'h08;
  localparam logic [4:0] OP_SRL = 5'h09;
  localparam logic [4:0] OP_SRA = 5'h0A;
  localparam logic [4:0] OP_MUL = 5'h0B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res_c;
  logic             zero_c;
  logic             carry_c;
  logic             ovf_c;
  logic             def_c;
  logic [WIDTH-1:0] acc_nxt_c;

  assign add_w     = {1'b0, alu_a} + {1'b0, alu_b};
  assign sub_w     = {1'b0, alu_a} - {1'b0, alu_b};
  assign sh        = alu_b[SHW-1:0];
  assign acc_nxt_c = mplier[0] ? acc + mcand : acc;

  // Single-cycle result and flags, evaluated straight from the request inputs
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    def_c   = 1'b1;
    case (alu_op)
      OP_NOP: res_c = '0;
      OP_ADD: begin
        res_c   = add_w[WIDTH-1:0];
        carry_c = add_w[WIDTH];
        ovf_c   = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (add_w[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = sub_w[WIDTH-1:0];
        carry_c = sub_w[WIDTH];
        ovf_c   = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (sub_w[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_AND: res_c = alu_a & alu_b;
      OP_OR:  res_c = alu_a | alu_b;
      OP_XOR: res_c = alu_a ^ alu_b;
      OP_NOR: res_c = ~(alu_a | alu_b);
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_SLL: res_c = alu_a << sh;
      OP_SRL: res_c = alu_a >> sh;
      OP_SRA: res_c = WIDTH'($signed(alu_a) >>> sh);
      default: def_c = 1'b0;
    endcase
    zero_c = def_c && (res_c == '0);
  end

  // Control FSM and registered datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      alu_out    <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (alu_op == OP_MUL) begin
              state  <= MUL;
              mcand  <= alu_a;
              mplier <= alu_b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              state      <= DONE;
              out_valid  <= 1'b1;
              alu_out    <= res_c;
              flag_zero  <= zero_c;
              flag_carry <= carry_c;
              flag_ovf   <= ovf_c;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state      <= DONE;
            cnt        <= '0;
            out_valid  <= 1'b1;
            alu_out    <= acc_nxt_c;
            flag_zero  <= (acc_nxt_c == '0);
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32: driver queues expected results,
// a negedge monitor checks result, flags and latency whenever out_valid is seen.
module tb_alu_mc;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [4:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_out    (alu_out),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         z;
    logic         c;
    logic         o;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(input string nm, input logic [W-1:0] o, input logic z,
                              input logic c, input logic v, input int lat);
    exp_t e;
    e.name = nm; e.out = o; e.z = z; e.c = c; e.o = v; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Monitor: latency on first sight of out_valid, full compare on handshake
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = q[0];
        if (!seen) begin
          seen = 1'b1;
          check({e.name, " latency"}, 64'(cyc - e.acc), 64'(e.lat));
        end
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
          check({e.name, " out"},   64'(alu_out),    64'(e.out));
          check({e.name, " zero"},  64'(flag_zero),  64'(e.z));
          check({e.name, " carry"}, 64'(flag_carry), 64'(e.c));
          check({e.name, " ovf"},   64'(flag_ovf),   64'(e.o));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input bit push);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check({e.name, " in_ready_timeout"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    alu_op   = op;
    alu_a    = a;
    alu_b    = b;
    e.acc    = cyc;
    if (push) q.push_back(e);
    step();
    in_valid = 1'b0;
    alu_a    = $urandom;
    alu_b    = $urandom;
    alu_op   = 5'h01;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_a = '0; alu_b = '0; alu_op = 5'h00;
    step();
    step();
    check("rst in_ready",  64'(in_ready),  64'(1));
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst alu_out",   64'(alu_out),   64'(0));
    check("rst flags",     64'({flag_zero, flag_carry, flag_ovf}), 64'(0));
    rst = 1'b0;
    step();

    issue(5'h01, 32'h7FFFFFFF, 32'h00000001, mk("add_ovf",  32'h80000000, 0, 0, 1, 1), 1);
    issue(5'h02, 32'd5,        32'd5,        mk("sub_zero", 32'h00000000, 1, 0, 0, 1), 1);
    issue(5'h02, 32'd0,        32'd1,        mk("sub_brw",  32'hFFFFFFFF, 0, 1, 0, 1), 1);
    issue(5'h0A, 32'h80000000, 32'd36,       mk("sra",      32'hF8000000, 0, 0, 0, 1), 1);
    issue(5'h09, 32'h80000000, 32'd36,       mk("srl",      32'h08000000, 0, 0, 0, 1), 1);
    issue(5'h08, 32'h80000000, 32'd36,       mk("sll",      32'h00000000, 1, 0, 0, 1), 1);
    issue(5'h01, 32'hFFFFFFFF, 32'h00000001, mk("add_cy",   32'h00000000, 1, 1, 0, 1), 1);
    issue(5'h02, 32'h80000000, 32'h00000001, mk("sub_ovf",  32'h7FFFFFFF, 0, 0, 1, 1), 1);
    issue(5'h03, 32'hF0F0F0F0, 32'h0FF00FF0, mk("and",      32'h00F000F0, 0, 0, 0, 1), 1);
    issue(5'h04, 32'h12340000, 32'h00005678, mk("or",       32'h12345678, 0, 0, 0, 1), 1);
    issue(5'h05, 32'hFFFF0000, 32'hFF00FF00, mk("xor",      32'h00FFFF00, 0, 0, 0, 1), 1);
    issue(5'h06, 32'h0F0F0F0F, 32'hF0F0F0F0, mk("nor",      32'h00000000, 1, 0, 0, 1), 1);
    issue(5'h07, 32'hFFFFFFFF, 32'h00000001, mk("slt_t",    32'h00000001, 0, 0, 0, 1), 1);
    issue(5'h07, 32'h00000005, 32'hFFFFFFFE, mk("slt_f",    32'h00000000, 1, 0, 0, 1), 1);
    issue(5'h00, 32'h12345678, 32'h9ABCDEF0, mk("nop",      32'h00000000, 1, 0, 0, 1), 1);
    issue(5'h1F, 32'h00000000, 32'h00000000, mk("undef",    32'h00000000, 0, 0, 0, 1), 1);

    // Multiply: in_ready low through MUL and the single DONE cycle
    issue(5'h0B, 32'hFFFFFFFF, 32'd3, mk("mul_neg", 32'hFFFFFFFD, 0, 0, 0, 33), 1);
    n = 0;
    while (in_ready === 1'b0 && n < 100) begin
      n++;
      step();
    end
    check("mul in_ready_low_cycles", 64'(n), 64'(33));
    issue(5'h0B, 32'd7, 32'd6, mk("mul_small", 32'h0000002A, 0, 0, 0, 33), 1);

    // Back-pressure: result held while out_ready is low
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    issue(5'h01, 32'd2, 32'd3, mk("stall_add", 32'h00000005, 0, 0, 0, 1), 1);
    for (int i = 0; i < 5; i++) begin
      check("stall out",      64'(alu_out),   64'(32'h5));
      check("stall flags",    64'({flag_zero, flag_carry, flag_ovf}), 64'(0));
      check("stall in_ready", 64'(in_ready),  64'(0));
      check("stall valid",    64'(out_valid), 64'(1));
      step();
    end
    out_ready = 1'b1;
    step();
    check("release in_ready",  64'(in_ready),  64'(1));
    check("release out_valid", 64'(out_valid), 64'(0));

    // Reset landing on multiply iteration 10 discards the operation
    issue(5'h0B, 32'h00001234, 32'h00000011, mk("mul_rst", 32'h0, 0, 0, 0, 33), 0);
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    check("midrst out_valid", 64'(out_valid), 64'(0));
    check("midrst alu_out",   64'(alu_out),   64'(0));
    check("midrst in_ready",  64'(in_ready),  64'(1));
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();

    n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("scoreboard drained", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", q.size());
    $fatal(1, "watchdog");
  end

endmodule
